// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1: asynchronous serial receiver for 7 data bits, even parity and one stop bit.
// The bit period is M clocks, and each bit is sampled at its centre after a half-bit start check.
module rx_serial_7e1 #(
   parameter int M = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       entrada_serial,
   input  logic       recebe,
   output logic [6:0] dados_ascii,
   output logic       pronto,
   output logic       tem_dado,
   output logic       erro_paridade,
   output logic       erro_stop,
   output logic       erro_overrun,
   output logic       ocupado,
   output logic [3:0] db_estado
);
   localparam int CW = $clog2(M);
   localparam logic [CW-1:0] HALF = CW'(M / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   typedef enum logic [3:0] {
      inicial  = 4'd0,
      start    = 4'd1,
      recepcao = 4'd2,
      stop     = 4'd3,
      armazena = 4'd4
   } estado_t;

   estado_t estado, proximo;
   logic s1, s2, s_ant, stop_bit, fim;
   logic [CW-1:0] cnt;
   logic [3:0] bits;
   logic [7:0] sh;

   assign fim       = cnt == LAST;
   assign ocupado   = estado != inicial;
   assign db_estado = estado;

   // s_ant trails the synchronizer so a start needs a real 1->0 edge, which also blocks restarts during a break
   always_ff @(posedge clock or negedge reset)
      if (!reset) {s1, s2, s_ant} <= 3'b111;
      else {s1, s2, s_ant} <= {entrada_serial, s1, s2};

   always_comb begin
      proximo = estado;
      case (estado)
         inicial:  proximo = (s_ant && !s2) ? start : inicial;
         start:    proximo = (cnt == HALF) ? (s2 ? inicial : recepcao) : start;
         recepcao: proximo = (fim && bits == 4'd7) ? stop : recepcao;
         stop:     proximo = fim ? armazena : stop;
         default:  proximo = inicial;
      endcase
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         estado        <= inicial;
         cnt           <= '0;
         bits          <= '0;
         sh            <= '0;
         stop_bit      <= 1'b1;
         dados_ascii   <= '0;
         pronto        <= 1'b0;
         tem_dado      <= 1'b0;
         erro_paridade <= 1'b0;
         erro_stop     <= 1'b0;
         erro_overrun  <= 1'b0;
      end else begin
         estado <= proximo;
         cnt    <= (estado != proximo || estado == inicial || fim) ? '0 : cnt + 1'b1;
         pronto <= estado == armazena;
         if (estado == inicial || estado == start) bits <= '0;
         else if (estado == recepcao && fim) begin
            bits <= bits + 4'd1;
            sh   <= {s2, sh[7:1]};
         end
         if (estado == stop && fim) stop_bit <= s2;
         // storing a frame takes priority over a simultaneous acknowledge
         if (estado == armazena) begin
            dados_ascii   <= sh[6:0];
            erro_paridade <= ^sh;
            erro_stop     <= ~stop_bit;
            tem_dado      <= 1'b1;
            if (tem_dado && !recebe) erro_overrun <= 1'b1;
         end else if (recebe && tem_dado) begin
            tem_dado     <= 1'b0;
            erro_overrun <= 1'b0;
         end
      end
endmodule

// File: tb/tb_rx_serial_7e1.sv
// tb_rx_serial_7e1: self-checking bench for rx_serial_7e1 with M=8.
// Frames are driven from a vector table plus hand sequences; stored characters are checked by a scoreboard on pronto.
module tb_rx_serial_7e1;
   localparam int M = 8;

   logic clock = 1'b0, reset = 1'b0, entrada_serial = 1'b1, recebe = 1'b0;
   logic [6:0] dados_ascii;
   logic [3:0] db_estado;
   logic pronto, tem_dado, erro_paridade, erro_stop, erro_overrun, ocupado;

   typedef struct {
      logic [6:0] d;
      logic       p;
      logic       s;
      logic [6:0] ed;
      logic       ep;
      logic       es;
   } vec_t;
   typedef struct {
      logic [6:0] d;
      logic       ep;
      logic       es;
   } exp_t;

   exp_t q[$];
   exp_t e;
   vec_t tbl[8];
   int nvec = 0, nerr = 0;
   logic seen;

   rx_serial_7e1 #(.M(M)) dut (
      .clock(clock), .reset(reset), .entrada_serial(entrada_serial), .recebe(recebe),
      .dados_ascii(dados_ascii), .pronto(pronto), .tem_dado(tem_dado),
      .erro_paridade(erro_paridade), .erro_stop(erro_stop), .erro_overrun(erro_overrun),
      .ocupado(ocupado), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1);
   end

   task automatic check(input string nome, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h", nome, act, exp);
      end
   endtask

   always @(negedge clock)
      if (reset && pronto) begin
         if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_pronto: got pronto with dados=%0h, required no pronto", dados_ascii);
         end else begin
            e = q.pop_front();
            check("sb_dados", int'(dados_ascii), int'(e.d));
            check("sb_erro_paridade", int'(erro_paridade), int'(e.ep));
            check("sb_erro_stop", int'(erro_stop), int'(e.es));
         end
      end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drive_bits(input logic [6:0] d, input logic p, input logic s);
      logic [9:0] f;
      f = {s, p, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         entrada_serial = f[i];
         idle(M);
      end
   endtask

   task automatic send(input logic [6:0] d, input logic p, input logic s, input logic ep, input logic es);
      q.push_back('{d, ep, es});
      drive_bits(d, p, s);
      entrada_serial = 1'b1;
      idle(3 * M);
   endtask

   task automatic ack;
      recebe = 1'b1;
      idle(1);
      recebe = 1'b0;
   endtask

   initial begin
      tbl[0] = '{7'h41, 1'b0, 1'b1, 7'h41, 1'b0, 1'b0};
      tbl[1] = '{7'h41, 1'b1, 1'b1, 7'h41, 1'b1, 1'b0};
      tbl[2] = '{7'h03, 1'b0, 1'b1, 7'h03, 1'b0, 1'b0};
      tbl[3] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0};
      tbl[4] = '{7'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0};
      tbl[5] = '{7'h2A, 1'b0, 1'b0, 7'h2A, 1'b1, 1'b1};
      tbl[6] = '{7'h55, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0};
      tbl[7] = '{7'h6C, 1'b1, 1'b1, 7'h6C, 1'b1, 1'b0};

      idle(3);
      check("rst_dados", int'(dados_ascii), 0);
      check("rst_pronto", int'(pronto), 0);
      check("rst_tem_dado", int'(tem_dado), 0);
      check("rst_erros", int'({erro_paridade, erro_stop, erro_overrun}), 0);
      check("rst_ocupado", int'(ocupado), 0);
      check("rst_estado", int'(db_estado), 0);
      reset = 1'b1;
      idle(4);

      for (int i = 0; i < 8; i++) begin
         send(tbl[i].d, tbl[i].p, tbl[i].s, tbl[i].ep, tbl[i].es);
         check($sformatf("v%0d_drain", i), q.size(), 0);
         check($sformatf("v%0d_dados", i), int'(dados_ascii), int'(tbl[i].ed));
         check($sformatf("v%0d_tem_dado", i), int'(tem_dado), 1);
         check($sformatf("v%0d_overrun", i), int'(erro_overrun), 0);
         check($sformatf("v%0d_ocupado", i), int'(ocupado), 0);
         ack();
         check($sformatf("v%0d_ack", i), int'(tem_dado), 0);
      end

      ack();
      check("idle_ack_tem_dado", int'(tem_dado), 0);
      check("idle_ack_overrun", int'(erro_overrun), 0);

      entrada_serial = 1'b0;
      idle(2);
      entrada_serial = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         if (ocupado) seen = 1'b1;
      end
      check("glitch_start", int'(seen), 1);
      for (int i = 0; i < 8 && ocupado; i++) idle(1);
      check("glitch_reject", int'(ocupado), 0);
      check("glitch_tem_dado", int'(tem_dado), 0);

      q.push_back('{7'h55, 1'b0, 1'b1});
      drive_bits(7'h55, 1'b0, 1'b0);
      idle(40);
      check("break_drain", q.size(), 0);
      check("break_erro_stop", int'(erro_stop), 1);
      check("break_ocupado", int'(ocupado), 0);
      entrada_serial = 1'b1;
      idle(3 * M);
      ack();

      send(7'h31, 1'b1, 1'b1, 1'b0, 1'b0);
      send(7'h32, 1'b1, 1'b1, 1'b0, 1'b0);
      check("ovr_drain", q.size(), 0);
      check("ovr_flag", int'(erro_overrun), 1);
      check("ovr_tem_dado", int'(tem_dado), 1);
      check("ovr_dados", int'(dados_ascii), 'h32);
      ack();
      check("ovr_ack_tem_dado", int'(tem_dado), 0);
      check("ovr_ack_flag", int'(erro_overrun), 0);

      send(7'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
      seen = 1'b0;
      fork
         send(7'h10, 1'b1, 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 12 * M && !seen; i++) begin
            idle(1);
            if (db_estado == 4'd4) begin
               seen = 1'b1;
               ack();
            end
         end
      join
      check("same_cycle_seen", int'(seen), 1);
      check("same_cycle_tem_dado", int'(tem_dado), 1);
      check("same_cycle_overrun", int'(erro_overrun), 0);
      check("same_cycle_dados", int'(dados_ascii), 'h10);

      entrada_serial = 1'b0;
      idle(3 * M);
      check("mid_in_recepcao", int'(db_estado), 2);
      reset = 1'b0;
      #1;
      check("mid_rst_dados", int'(dados_ascii), 0);
      check("mid_rst_tem_dado", int'(tem_dado), 0);
      check("mid_rst_pronto", int'(pronto), 0);
      check("mid_rst_erros", int'({erro_paridade, erro_stop, erro_overrun}), 0);
      check("mid_rst_ocupado", int'(ocupado), 0);
      check("mid_rst_estado", int'(db_estado), 0);
      entrada_serial = 1'b1;
      idle(4);
      reset = 1'b1;
      idle(4);
      send(7'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
      check("post_rst_drain", q.size(), 0);
      check("post_rst_tem_dado", int'(tem_dado), 1);
      check("post_rst_dados", int'(dados_ascii), 'h7F);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
